// File: rtl/ram_burst_pkg.sv
// Shared widths and FSM state encoding for the RAM burst master and its read skid buffer.
package ram_burst_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int LEN_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } burst_state_e;

  // Reads in flight toward the skid buffer plus words already parked in it.
  function automatic logic [1:0] inFlight(input logic outstanding, input logic [1:0] occupancy);
    return {1'b0, outstanding} + occupancy;
  endfunction

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry valid/ready FIFO that catches RAM read returns so rd_ready never stalls the RAM pipeline.
module ram_rd_skid #(
  parameter int DATA_W = ram_burst_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] pushData_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] popData_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);
  import ram_burst_pkg::*;

  logic [DATA_W-1:0] mem_q [2];
  logic              wrPtr_q;
  logic              rdPtr_q;
  logic [1:0]        count_q;
  logic              pushEn;
  logic              popEn;

  assign pushEn    = push_i && (count_q != 2'd2);
  assign popEn     = pop_i && (count_q != 2'd0);
  assign popData_o = mem_q[rdPtr_q];
  assign valid_o   = (count_q != 2'd0);
  assign count_o   = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (pushEn) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (popEn) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port word RAM: write bursts drain a stream into RAM,
// read bursts stream RAM words out with backpressure through a two-entry skid buffer.
module ram_burst_master #(
  parameter int DATA_W = ram_burst_pkg::DATA_W,
  parameter int ADDR_W = ram_burst_pkg::ADDR_W,
  parameter int LEN_W  = ram_burst_pkg::LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_d_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i
);
  import ram_burst_pkg::*;

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_WRITE = ST_WRITE;
  localparam logic [2:0] S_READ  = ST_READ;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] curAddr_q, curAddr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              outstanding_q;
  logic              armed_q;

  logic              cmdReady;
  logic              wrBeat;
  logic              rdIssue;
  logic              rdPop;
  logic              skidValid;
  logic [1:0]        skidCount;
  logic [DATA_W-1:0] skidData;
  logic              lastWord;

  ram_rd_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (outstanding_q),
    .pushData_i (ram_q_i),
    .pop_i      (rdPop),
    .popData_o  (skidData),
    .valid_o    (skidValid),
    .count_o    (skidCount)
  );

  // A slot freed by this cycle's pop may be reused by this cycle's issue, which keeps
  // one word per cycle flowing while the in-flight total never exceeds two.
  assign cmdReady = (state_q == S_IDLE) && armed_q;
  assign wrBeat   = (state_q == S_WRITE) && wr_valid_i;
  assign rdPop    = skidValid && rd_ready_i;
  assign rdIssue  = (state_q == S_READ) &&
                    ((inFlight(outstanding_q, skidCount) < 2'd2) || rdPop);
  assign lastWord = (remaining_q == LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    curAddr_d   = curAddr_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmdReady) begin
          curAddr_d   = cmd_addr_i;
          remaining_d = cmd_len_i;
          if (cmd_len_i == '0) begin
            state_d = S_DONE;
          end else if (cmd_write_i) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        if (wrBeat) begin
          curAddr_d   = curAddr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (lastWord) begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (rdIssue) begin
          curAddr_d   = curAddr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (lastWord) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!outstanding_q && ((skidCount == 2'd0) || ((skidCount == 2'd1) && rdPop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // armed_q holds cmd_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      curAddr_q     <= '0;
      remaining_q   <= '0;
      outstanding_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      curAddr_q     <= curAddr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= rdIssue;
      armed_q       <= 1'b1;
    end
  end

  assign cmd_ready_o = cmdReady;
  assign wr_ready_o  = (state_q == S_WRITE);
  assign rd_valid_o  = skidValid;
  assign rd_data_o   = skidData;
  assign busy_o      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign ram_addr_o  = ((state_q == S_WRITE) || (state_q == S_READ)) ? curAddr_q : '0;
  assign ram_d_o     = wrBeat ? wr_data_i : '0;
  assign ram_wren_o  = wrBeat;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: behavioural RAM, shadow memory model and stream scoreboard.
module tb_ram_burst_master;

  localparam int DW    = 32;
  localparam int AW    = 14;
  localparam int LW    = 9;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wrEv_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          cmdValid, cmdReady, cmdWrite;
  logic [AW-1:0] cmdAddr;
  logic [LW-1:0] cmdLen;
  logic          wrValid, wrReady;
  logic [DW-1:0] wrData;
  logic          rdValid, rdReady;
  logic [DW-1:0] rdData;
  logic          busy, done;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramD;
  logic          ramWren;
  logic [DW-1:0] ramQ;

  logic [DW-1:0] ramMem [DEPTH];
  logic [DW-1:0] refMem [DEPTH];
  logic          memInit = 1'b0;
  logic [DW-1:0] memSeed;

  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;
  int            doneCount  = 0;
  int            doneCyc    = 0;
  bit            inWriteBurst = 1'b0;
  bit            prevHold   = 1'b0;
  logic [DW-1:0] prevData;
  wrEv_t         obsWr [$];
  logic [DW-1:0] obsRd [$];
  int            rdCyc [$];

  always #5 clk = ~clk;

  ram_burst_master dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_write_i (cmdWrite),
    .cmd_addr_i  (cmdAddr),
    .cmd_len_i   (cmdLen),
    .wr_valid_i  (wrValid),
    .wr_ready_o  (wrReady),
    .wr_data_i   (wrData),
    .rd_valid_o  (rdValid),
    .rd_ready_i  (rdReady),
    .rd_data_o   (rdData),
    .busy_o      (busy),
    .done_o      (done),
    .ram_addr_o  (ramAddr),
    .ram_d_o     (ramD),
    .ram_wren_o  (ramWren),
    .ram_q_i     (ramQ)
  );

  function automatic logic [DW-1:0] initWord(input int i);
    return (DW'(i) * 32'h9E37_79B1) ^ memSeed;
  endfunction

  // Single-port synchronous RAM; contents are seeded on the first edge.
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < DEPTH; i++) ramMem[i] <= initWord(i);
      memInit <= 1'b1;
    end else if (ramWren) begin
      ramMem[ramAddr] <= ramD;
    end else begin
      ramQ <= ramMem[ramAddr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Passive monitor: logs RAM writes, accepted read words and done pulses; checks stream holding.
  always @(negedge clk) begin
    if (!rstN) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("rd_hold_valid", rdValid, 1);
        checkOutput("rd_hold_data", rdData, prevData);
      end
      prevHold = rdValid && !rdReady;
      prevData = rdData;
      if (ramWren) begin
        obsWr.push_back(wrEv_t'{ramAddr, ramD, cyc});
        checkOutput("wren_only_in_write", inWriteBurst, 1);
      end
      if (rdValid && rdReady) begin
        obsRd.push_back(rdData);
        rdCyc.push_back(cyc);
      end
      if (done) begin
        doneCount++;
        doneCyc = cyc;
        checkOutput("done_busy_low", busy, 0);
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input int len, output int accCyc);
    int n = 0;
    @(posedge clk); #1;
    cmdValid = 1'b1;
    cmdWrite = w;
    cmdAddr  = a;
    cmdLen   = LW'(len);
    @(negedge clk);
    while (!cmdReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept_timeout", (n < 200), 1);
    @(posedge clk); #1;
    accCyc   = cyc;
    cmdValid = 1'b0;
    cmdWrite = $urandom_range(1, 0);
    cmdAddr  = AW'($urandom);
    cmdLen   = LW'($urandom);
  endtask

  // gap < 0 selects random idle cycles between beats; seq selects data base+i.
  task automatic writeBurst(input logic [AW-1:0] a, input int len, input int gap,
                            input bit seq, input logic [DW-1:0] base);
    int            acc, startDone, n, g;
    logic [DW-1:0] d;
    logic [DW-1:0] sent [$];
    startDone = doneCount;
    obsWr.delete();
    inWriteBurst = 1'b1;
    applyStimulus(1'b1, a, len, acc);
    for (int i = 0; i < len; i++) begin
      g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(2, 0)) : gap);
      wrValid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      d = seq ? (base + DW'(i)) : DW'($urandom);
      sent.push_back(d);
      refMem[(int'(a) + i) % DEPTH] = d;
      wrValid = 1'b1;
      wrData  = d;
      n = 0;
      @(negedge clk);
      if (i == 0) checkOutput("wr_busy", busy, 1);
      while (!wrReady && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
    end
    wrValid = 1'b0;
    n = 0;
    while (doneCount == startDone && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    inWriteBurst = 1'b0;
    checkOutput("wr_done_once", doneCount - startDone, 1);
    checkOutput("wr_beats", obsWr.size(), len);
    for (int i = 0; i < len && i < obsWr.size(); i++) begin
      checkOutput($sformatf("wr_addr%0d", i), obsWr[i].addr, (int'(a) + i) % DEPTH);
      checkOutput($sformatf("wr_data%0d", i), obsWr[i].data, sent[i]);
    end
    if (obsWr.size() == len) begin
      checkOutput("wr_done_after_last", doneCyc, obsWr[len-1].cyc + 1);
      if (gap >= 0) checkOutput("wr_spacing", obsWr[len-1].cyc - obsWr[0].cyc, (len - 1) * (gap + 1));
    end
  endtask

  // mode 0: rd_ready always 1; mode 1: 1,0,0,1,0,1 then random; mode 2: random.
  task automatic readBurst(input logic [AW-1:0] a, input int len, input int mode);
    int acc, startDone, n;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    startDone = doneCount;
    obsRd.delete();
    rdCyc.delete();
    applyStimulus(1'b0, a, len, acc);
    rdReady = (mode == 0) ? 1'b1 : ((mode == 1) ? pat[0] : 1'($urandom_range(1, 0)));
    @(negedge clk);
    checkOutput("rd_busy", busy, 1);
    n = 0;
    while (doneCount == startDone && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (mode == 0)                rdReady = 1'b1;
      else if (mode == 1 && n < 6)  rdReady = pat[n];
      else                          rdReady = 1'($urandom_range(1, 0));
    end
    rdReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rd_done_once", doneCount - startDone, 1);
    checkOutput("rd_words", obsRd.size(), len);
    for (int i = 0; i < len && i < obsRd.size(); i++) begin
      checkOutput($sformatf("rd_data%0d", i), obsRd[i], refMem[(int'(a) + i) % DEPTH]);
    end
    if (mode == 0 && obsRd.size() == len) begin
      checkOutput("rd_first_latency", rdCyc[0] - acc, 2);
      checkOutput("rd_throughput", rdCyc[len-1] - rdCyc[0], len - 1);
      checkOutput("rd_done_cyc", doneCyc - acc, len + 2);
    end
  endtask

  initial begin
    int acc, startDone, n;
    memSeed  = $urandom;
    rstN     = 1'b0;
    cmdValid = 1'b0;
    cmdWrite = 1'b0;
    cmdAddr  = '0;
    cmdLen   = '0;
    wrValid  = 1'b0;
    wrData   = '0;
    rdReady  = 1'b0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);

    // Reset state and cmd_ready release timing.
    #12;
    checkOutput("rst_cmd_ready", cmdReady, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_valid", rdValid, 0);
    checkOutput("rst_ram_wren", ramWren, 0);
    @(negedge clk); #1;
    rstN = 1'b1;
    #1;
    checkOutput("rel_cmd_ready_low", cmdReady, 0);
    @(posedge clk); #1;
    checkOutput("rel_cmd_ready_high", cmdReady, 1);

    // Write then read back at 0x20.
    writeBurst(14'h20, 4, 0, 1'b1, 32'hA0);
    readBurst(14'h20, 4, 0);

    // Read backpressure over a freshly written region.
    writeBurst(14'h100, 6, -1, 1'b0, '0);
    readBurst(14'h100, 6, 1);

    // Address wrap at the top of the RAM.
    writeBurst(14'h3FFF, 3, 0, 1'b1, 32'd1);
    checkOutput("wrap_ram_top", ramMem[16383], 1);
    checkOutput("wrap_ram_0", ramMem[0], 2);
    checkOutput("wrap_ram_1", ramMem[1], 3);
    readBurst(14'h3FFF, 3, 0);

    // Zero-length commands in both directions.
    for (int w = 0; w < 2; w++) begin
      startDone = doneCount;
      obsWr.delete();
      obsRd.delete();
      applyStimulus(1'(w), AW'($urandom), 0, acc);
      @(negedge clk);
      checkOutput("zl_done", done, 1);
      checkOutput("zl_cmd_ready_low", cmdReady, 0);
      @(negedge clk);
      checkOutput("zl_cmd_ready", cmdReady, 1);
      checkOutput("zl_no_write", obsWr.size(), 0);
      checkOutput("zl_no_read", obsRd.size(), 0);
      checkOutput("zl_done_once", doneCount - startDone, 1);
    end

    // Write starvation: five idle cycles between two beats.
    writeBurst(14'h200, 2, 5, 1'b0, '0);

    // Randomized bursts.
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      int            len;
      a   = AW'($urandom);
      len = $urandom_range(12, 1);
      writeBurst(a, len, -1, 1'b0, '0);
      readBurst(a, len, 2);
    end

    // Reset in the middle of a read burst.
    startDone = doneCount;
    obsRd.delete();
    applyStimulus(1'b0, 14'h10, 8, acc);
    rdReady = 1'b1;
    n = 0;
    while (obsRd.size() < 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_cmd_ready", cmdReady, 0);
    checkOutput("mid_rst_wr_ready", wrReady, 0);
    checkOutput("mid_rst_rd_valid", rdValid, 0);
    checkOutput("mid_rst_rd_data", rdData, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_ram_addr", ramAddr, 0);
    checkOutput("mid_rst_ram_d", ramD, 0);
    checkOutput("mid_rst_ram_wren", ramWren, 0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_rst_words", obsRd.size(), 3);
    for (int i = 0; i < 3 && i < obsRd.size(); i++) begin
      checkOutput($sformatf("mid_rst_data%0d", i), obsRd[i], refMem[16 + i]);
    end
    rstN = 1'b1;
    rdReady = 1'b0;
    #1;
    checkOutput("mid_rst_cmd_ready_low", cmdReady, 0);
    @(posedge clk); #1;
    checkOutput("mid_rst_cmd_ready_high", cmdReady, 1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mid_rst_no_done", doneCount, startDone);

    // A fresh command is accepted after the abort.
    writeBurst(14'h10, 3, -1, 1'b0, '0);
    readBurst(14'h10, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
